// File: rtl/instruction_loader.sv
// Byte-stream instruction loader: assembles little-endian 32-bit words and writes them to instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
    parameter int MAX_WORDS  = 101,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            num_words,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int unsigned MAX_U = MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  fin_err_s;
    logic                  too_many_s;
    logic                  last_word_s;
    logic [7:0]            num_words_r;
    logic [7:0]            word_idx_r;
    logic [1:0]            byte_idx_r;
    logic [23:0]           asm_r;
    logic [7:0]            xor_r;
    logic                  chk_phase_r;
    logic                  byte_ready_s, mem_we_s, busy_s, done_s, error_s;
    logic                  byte_ready_r, mem_we_r, busy_r, done_r, error_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;

    assign too_many_s  = {24'd0, num_words} > MAX_U;
    assign last_word_s = (word_idx_r + 8'd1) == num_words_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; fin_err_s flags a failing load on the way into FINISH
    always_comb begin
        state_next_s = state_r;
        fin_err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_words == 8'd0) begin
                        state_next_s = FINISH;
                    end else if (too_many_s) begin
                        state_next_s = FINISH;
                        fin_err_s    = 1'b1;
                    end else begin
                        state_next_s = RECV;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RECV: begin
                if (!byte_valid) begin
                    state_next_s = RECV;
                end else if (chk_phase_r) begin
                    state_next_s = FINISH;
                    fin_err_s    = (byte_in != xor_r);
                end else if (byte_idx_r == 2'd3) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RECV;
                end
            end
            WRITE: begin
                if (last_word_s && CHK_EN) begin
                    state_next_s = RECV;
                end else if (last_word_s) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = RECV;
                end
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        byte_ready_s = (state_next_s == RECV);
        mem_we_s     = (state_next_s == WRITE);
        busy_s       = (state_next_s != IDLE);
        done_s       = (state_next_s == FINISH);
        error_s      = fin_err_s;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_s;
            mem_we_r     <= mem_we_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
        end
    end

    // Datapath: word/byte counters, byte assembly, running XOR, write address/data
    always_ff @(posedge clk) begin
        if (rst) begin
            num_words_r <= 8'd0;
            word_idx_r  <= 8'd0;
            byte_idx_r  <= 2'd0;
            asm_r       <= 24'd0;
            xor_r       <= 8'd0;
            chk_phase_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
        end else if (state_r == IDLE) begin
            if (start) begin
                num_words_r <= num_words;
                word_idx_r  <= 8'd0;
                byte_idx_r  <= 2'd0;
                xor_r       <= 8'd0;
                chk_phase_r <= 1'b0;
            end else begin
                num_words_r <= num_words_r;
            end
        end else if (state_r == RECV && byte_valid && !chk_phase_r) begin
            xor_r      <= xor_r ^ byte_in;
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
                2'd0:    asm_r[7:0]   <= byte_in;
                2'd1:    asm_r[15:8]  <= byte_in;
                2'd2:    asm_r[23:16] <= byte_in;
                default: begin
                    mem_wdata_r <= {byte_in, asm_r};
                    mem_addr_r  <= ADDR_WIDTH'({22'd0, word_idx_r, 2'b00});
                end
            endcase
        end else if (state_r == WRITE) begin
            word_idx_r <= word_idx_r + 8'd1;
            if (last_word_s) begin
                chk_phase_r <= CHK_EN;
            end else begin
                chk_phase_r <= 1'b0;
            end
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    assign byte_ready = byte_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: directed and randomized loads against a word-level reference model.
module tb_instruction_loader;

    localparam int MAXW = 101;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_words = 8'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    instruction_loader #(.MAX_WORDS(MAXW), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pay_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation per write strobe or done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_we) begin
                check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none", mem_addr, mem_wdata);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: error=%0d, expected a write or nothing", error);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    check("done_error", {31'd0, error}, {31'd0, e.err});
                end
            end else if (error) begin
                tests++; fails++;
                $display("FAIL error_without_done: got error=1, expected 0");
            end
            if (prev_done) check("busy_after_done", {31'd0, busy}, 32'd0);
            prev_done = done;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL byte_timeout: byte_ready stayed 0, expected 1");
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 400 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy stayed 1, expected 0");
        end
        @(posedge clk); #1;
    endtask

    // Reference model plus driver. chk_val < 0 sends the correct checksum byte.
    // gap_mode: 0 back-to-back, 1 alternating, 2 random gaps.
    task automatic do_load(input int n, input int chk_val, input int gap_mode, input bit poke_start);
        exp_t        e;
        logic [7:0]  xr = 8'd0;
        logic [7:0]  cb;
        int          gap;
        bit          bad = (n == 0) || (n > MAXW);
        if (!bad) begin
            for (int w = 0; w < n; w++) begin
                e.is_done = 1'b0;
                e.addr    = 32'(w * 4);
                e.data    = pay_q[4*w] + (pay_q[4*w+1] << 8) + (pay_q[4*w+2] << 16) + (pay_q[4*w+3] << 24);
                e.err     = 1'b0;
                exp_q.push_back(e);
                for (int j = 0; j < 4; j++) xr = xr ^ 8'(pay_q[4*w+j]);
            end
        end
        cb        = (chk_val < 0) ? xr : 8'(chk_val);
        e.is_done = 1'b1;
        e.addr    = 32'd0;
        e.data    = 32'd0;
        e.err     = (n > MAXW) || (CHK && !bad && cb != xr);
        exp_q.push_back(e);

        start = 1'b1; num_words = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (bad) begin
            @(negedge clk);
            check("early_done", {31'd0, done}, 32'd1);
            check("early_error", {31'd0, error}, {31'd0, n > MAXW});
        end else begin
            if (poke_start) begin
                start = 1'b1; num_words = 8'd0;
                @(posedge clk); #1;
                start = 1'b0;
            end
            for (int i = 0; i < 4 * n; i++) begin
                gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                send_byte(8'(pay_q[i]), gap);
            end
            if (CHK) send_byte(cb, 0);
        end
        wait_idle();
    endtask

    task automatic set_directed(input logic [63:0] bytes, input int cnt);
        pay_q.delete();
        for (int i = 0; i < cnt; i++) pay_q.push_back(int'(bytes[8*i +: 8]));
    endtask

    task automatic set_random(input int n);
        pay_q.delete();
        for (int i = 0; i < 4 * n; i++) pay_q.push_back($urandom_range(0, 255));
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        @(posedge clk); #1;

        set_directed(64'h0000_0000_E3A0_0014, 4);
        do_load(1, -1, 0, 1'b0);
        set_directed(64'hE3A0_1A01_E3A0_0014, 8);
        do_load(2, -1, 0, 1'b0);
        set_directed(64'd0, 0);
        do_load(102, -1, 0, 1'b0);
        do_load(0, -1, 0, 1'b0);
        set_directed(64'h0000_0000_E3A0_0014, 4);
        do_load(1, -1, 1, 1'b1);
        if (CHK) begin
            do_load(1, 8'h57, 0, 1'b0);
            do_load(1, 8'h00, 0, 1'b0);
        end

        // Abort after two bytes, then a fresh load must start clean
        start = 1'b1; num_words = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        set_directed(64'h0000_0000_E3A0_0014, 4);
        do_load(1, -1, 2, 1'b0);

        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = int'($urandom_range(MAXW + 1, 255));
                default: n = int'($urandom_range(1, 5));
            endcase
            set_random((n > MAXW) ? 0 : n);
            do_load(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1,
                    int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
